instruction_fetch_mem: RTL and testbench

Parametrised successor to the single-port instruction store. Holds the program in a word array and serves byte-addressed fetches from the PC stage over a valid/ready request/response handshake, with one-cycle latency. A stalled response is held until consumed. Additional features: pipeline flush, fault flagging for misaligned and out-of-range addresses, and a write (load) port for programming. After reset, an optional clear sweep fills memory with NOP.

---
 rtl/instruction_fetch_mem_pkg.sv | 16 +
 rtl/imem_array.sv | 24 ++
 rtl/instruction_fetch_mem.sv | 105 ++++++++++
 tb/tb_instruction_fetch_mem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_mem_pkg.sv
// rtl/instruction_fetch_mem_pkg.sv - shared constants, state encoding and fault check for the fetch store
package instruction_fetch_mem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000013;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Full-width compare so addresses above the array fault instead of aliasing.
  function automatic logic addr_fault(input logic [63:0] addr, input logic [63:0] depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 1R1W synchronous word RAM, read-first, no reset
module imem_array #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Read and write share one edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_fetch_mem.sv
// rtl/instruction_fetch_mem.sv - instruction store with valid/ready fetch port, flush, faults and load port
module instruction_fetch_mem
  import instruction_fetch_mem_pkg::*;
#(
  parameter int                DWIDTH         = 32,
  parameter int                MEMDEPTH       = 1024,
  parameter int                AWIDTH         = $clog2(MEMDEPTH),
  parameter logic [DWIDTH-1:0] NOP_WORD       = DWIDTH'(NOP_WORD_DEFAULT),
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [DWIDTH-1:0] fetch_addr,
  output logic              fetch_rsp_valid,
  input  logic              fetch_rsp_ready,
  output logic [DWIDTH-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              flush,
  input  logic              load_we,
  input  logic [DWIDTH-1:0] load_addr,
  input  logic [DWIDTH-1:0] load_data,
  output logic              init_done
);

  state_t            state, state_next;
  logic [AWIDTH-1:0] cnt;
  logic              rsp_blank;
  logic              rsp_fault;
  logic              accept;
  logic              req_fault;
  logic              load_fault;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_waddr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;

  assign req_fault  = addr_fault(64'(fetch_addr), 64'(MEMDEPTH));
  assign load_fault = addr_fault(64'(load_addr), 64'(MEMDEPTH));
  assign accept     = fetch_req_valid && fetch_req_ready;

  always_comb begin
    state_next      = state;
    fetch_req_ready = 1'b0;
    ram_we          = 1'b0;
    ram_waddr       = cnt;
    ram_wdata       = NOP_WORD;
    case (state)
      ST_INIT: begin
        ram_we = 1'b1;
        if (cnt == AWIDTH'(MEMDEPTH - 1)) state_next = ST_RUN;
      end
      ST_RUN: begin
        fetch_req_ready = !flush && (!fetch_rsp_valid || fetch_rsp_ready);
        ram_we          = load_we && !load_fault;
        ram_waddr       = load_addr[AWIDTH+1:2];
        ram_wdata       = load_data;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt             <= '0;
      fetch_rsp_valid <= 1'b0;
      rsp_fault       <= 1'b0;
      rsp_blank       <= 1'b1;
      init_done       <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == ST_RUN);
      if (state == ST_INIT) cnt <= cnt + AWIDTH'(1);
      if (state == ST_RUN && flush) begin
        fetch_rsp_valid <= 1'b0;
      end else if (accept) begin
        fetch_rsp_valid <= 1'b1;
        rsp_fault       <= req_fault;
        rsp_blank       <= 1'b0;
      end else if (fetch_rsp_ready) begin
        fetch_rsp_valid <= 1'b0;
      end
    end
  end

  // RAM output holds between reads, so the response data needs no extra register.
  assign fetch_instr = rsp_blank ? '0 : (rsp_fault ? NOP_WORD : ram_rdata);
  assign fetch_fault = rsp_fault;

  imem_array #(
    .DWIDTH(DWIDTH),
    .DEPTH (MEMDEPTH),
    .AWIDTH(AWIDTH)
  ) u_imem_array (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (accept),
    .raddr(fetch_addr[AWIDTH+1:2]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// tb/tb_instruction_fetch_mem.sv - directed and randomized bench for instruction_fetch_mem with reference model
module tb_instruction_fetch_mem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [31:0] fetch_addr;
  logic        fetch_rsp_valid;
  logic        fetch_rsp_ready;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        flush;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  bit          m_run;
  int          m_cnt;
  bit          m_valid;
  logic [31:0] m_instr;
  bit          m_fault;
  logic [31:0] model_mem [DEPTH];

  instruction_fetch_mem #(
    .DWIDTH        (32),
    .MEMDEPTH      (DEPTH),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_ready(fetch_req_ready),
    .fetch_addr     (fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid),
    .fetch_rsp_ready(fetch_rsp_ready),
    .fetch_instr    (fetch_instr),
    .fetch_fault    (fetch_fault),
    .flush          (flush),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .init_done      (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic idle();
    fetch_req_valid = 1'b0;
    fetch_addr      = '0;
    fetch_rsp_ready = 1'b1;
    flush           = 1'b0;
    load_we         = 1'b0;
    load_addr       = '0;
    load_data       = '0;
  endtask

  // One clock: predict from current inputs, advance, compare all outputs.
  task automatic cyc();
    bit exp_ready;
    bit acc;
    #1;
    exp_ready = m_run && !flush && (!m_valid || fetch_rsp_ready);
    chk("ready", 32'(fetch_req_ready), 32'(exp_ready));
    acc = fetch_req_valid && exp_ready;
    if (!m_run) begin
      model_mem[m_cnt] = NOP;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else begin
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1;
        m_fault = ref_fault(fetch_addr);
        if (m_fault) m_instr = NOP;
        else         m_instr = model_mem[fetch_addr / 4];
      end else if (fetch_rsp_ready) begin
        m_valid = 1'b0;
      end
      if (load_we && !ref_fault(load_addr)) model_mem[load_addr / 4] = load_data;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(fetch_rsp_valid), 32'(m_valid));
    chk("instr", fetch_instr, m_instr);
    chk("fault", 32'(fetch_fault), 32'(m_fault));
    chk("init_done", 32'(init_done), 32'(m_run));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    m_run   = 1'b0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_instr = '0;
    m_fault = 1'b0;
    chk("rst_valid", 32'(fetch_rsp_valid), 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(fetch_req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic sweep();
    int n;
    n = 0;
    fetch_req_valid = 1'b1;
    fetch_addr      = 32'h0;
    while (!init_done && n < 40) begin
      cyc();
      n++;
    end
    chk("sweep_len", n, 32'd16);
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    do_reset();
    sweep();

    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    cyc();
    chk("first_fetch_nop", fetch_instr, NOP);
    idle();

    load_we = 1'b1; load_addr = 32'h8; load_data = 32'hDEADBEEF;
    cyc();
    load_addr = 32'hC; load_data = 32'h12345678;
    cyc();
    idle();
    fetch_req_valid = 1'b1; fetch_addr = 32'h8;
    cyc();
    chk("b2b_first", fetch_instr, 32'hDEADBEEF);
    fetch_addr = 32'hC;
    cyc();
    chk("b2b_second", fetch_instr, 32'h12345678);
    idle();
    cyc();

    fetch_req_valid = 1'b1; fetch_addr = 32'h8;
    cyc();
    fetch_addr = 32'hC; fetch_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", fetch_instr, 32'hDEADBEEF);
    end
    fetch_rsp_ready = 1'b1;
    cyc();
    chk("stall_release", fetch_instr, 32'h12345678);

    fetch_addr = 32'h6;
    cyc();
    chk("misaligned_fault", 32'(fetch_fault), 32'd1);
    chk("misaligned_instr", fetch_instr, NOP);
    fetch_addr = 32'h40;
    cyc();
    chk("range_fault", 32'(fetch_fault), 32'd1);
    idle();
    load_we = 1'b1; load_addr = 32'h42; load_data = 32'h55555555;
    cyc();
    load_addr = 32'h40;
    cyc();
    idle();
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    cyc();
    chk("dropped_load", fetch_instr, NOP);

    fetch_addr = 32'h8; fetch_rsp_ready = 1'b0;
    cyc();
    flush = 1'b1;
    cyc();
    chk("flush_valid", 32'(fetch_rsp_valid), 32'd0);
    idle();
    cyc();
    chk("flush_no_accept", 32'(fetch_rsp_valid), 32'd0);

    fetch_req_valid = 1'b1; fetch_addr = 32'h4;
    load_we = 1'b1; load_addr = 32'h4; load_data = 32'hAAAA0000;
    cyc();
    chk("collision_old", fetch_instr, NOP);
    load_we = 1'b0;
    cyc();
    chk("collision_new", fetch_instr, 32'hAAAA0000);
    idle();

    for (int i = 0; i < 400; i++) begin
      fetch_req_valid = ($urandom_range(0, 3) != 0);
      fetch_addr      = $urandom_range(0, 19) * 4;
      if ($urandom_range(0, 7) == 0) fetch_addr = fetch_addr + $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) fetch_addr = $urandom;
      fetch_rsp_ready = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      load_we         = ($urandom_range(0, 3) == 0);
      load_addr       = $urandom_range(0, 19) * 4;
      if ($urandom_range(0, 7) == 0) load_addr = load_addr + $urandom_range(1, 3);
      load_data       = $urandom;
      cyc();
    end
    idle();
    cyc();

    fetch_req_valid = 1'b1; fetch_addr = 32'h8; fetch_rsp_ready = 1'b0;
    cyc();
    idle();
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    do_reset();
    sweep();
    fetch_req_valid = 1'b1; fetch_addr = 32'h8;
    cyc();
    chk("recleared", fetch_instr, NOP);
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
